ballot_arbiter: RTL and testbench
=================================

Name: ballot_arbiter

Overview:
- Shares one vote tally unit among NUM_BOOTHS voting booths.
- Grants booths one at a time, round-robin, and opens one bounded vote window per grant.
- Checks that each vote selects exactly one candidate, then forwards it to the tally as a single ready/valid transfer.
- Enforces the Close and Clear session controls and counts ballots issued for the Total display path.

Parameters:
- NUM_BOOTHS, 4: number of requesting booths.
- NUM_CAND, 4: candidates per ballot; booth input is one-hot of this width.
- TIMEOUT, 8: cycles a granted booth has to present a vote, 1..255.
- CNT_W, 12: width of the ballots_issued counter, matching the 12-bit display.

Ports:
- clk, in, 1: system clock, rising edge.
- Power, in, 1: asynchronous active-low reset; Power=0 is machine off.
- Clear, in, 1: synchronous session clear, active-high.
- Close, in, 1: synchronous close of voting, active-high.
- booth_req, in, NUM_BOOTHS: level ballot request, one bit per booth.
- booth_in, in, NUM_BOOTHS*NUM_CAND: candidate select. Booth b uses bits [b*NUM_CAND +: NUM_CAND].
- booth_gnt, out, NUM_BOOTHS: one-hot grant, held for one ballot.
- booth_done, out, NUM_BOOTHS: 1-cycle pulse when the booth's vote is accepted by the tally.
- booth_err, out, NUM_BOOTHS: 1-cycle pulse when the ballot is spoiled (multi-hot) or times out.
- vote_valid, out, 1: a vote is offered to the tally.
- vote_cand, out, $clog2(NUM_CAND): index of the offered candidate.
- vote_ready, in, 1: tally accepts the vote.
- closed, out, 1: session is closed.
- ballots_issued, out, CNT_W: count of votes accepted by the tally.

Behaviour:
- Reset (Power=0, asynchronous):
  - state=IDLE, RR pointer=0, timer=0, close_pend=0.
  - All outputs are 0, including booth_gnt, booth_done, booth_err, vote_valid, vote_cand, closed and ballots_issued.
- All outputs are registered.
- FSM states: IDLE, WAIT, SEND, CLOSED.
- Priority, highest first: Clear, then Close, then normal flow.
- IDLE:
  - If Close: go to CLOSED.
  - Else if any booth_req: pick the first requester at or after the RR pointer, wrapping. Assert its booth_gnt, load timer=TIMEOUT-1, go to WAIT.
  - Grant appears the cycle after the request is sampled.
  - If no request: stay in IDLE.
- WAIT, sampling the granted booth's slice every cycle:
  - Exactly one bit set: latch its index into vote_cand, go to SEND.
  - Two or more bits set: spoiled ballot. Pulse booth_err, drop the grant, go to IDLE. No vote is sent.
  - All zero with timer>0: decrement timer.
  - All zero with timer==0: pulse booth_err, drop the grant, go to IDLE.
  - booth_req falling during WAIT is ignored; the grant persists until done or err.
- SEND:
  - vote_valid=1; vote_cand is stable while valid.
  - On the cycle vote_valid and vote_ready are both 1:
    - pulse booth_done;
    - drop booth_gnt and vote_valid the next cycle;
    - increment ballots_issued, saturating at 2^CNT_W-1;
    - go to IDLE.
  - vote_ready low stalls indefinitely; there is no timeout in SEND.
- RR pointer:
  - Set to granted index +1 (mod NUM_BOOTHS) when a grant ends, whether by done or err.
  - A booth therefore cannot win twice in a row while another booth is requesting.
- Close during WAIT or SEND:
  - Sets close_pend; the in-flight ballot completes normally.
  - Then go to CLOSED instead of IDLE.
- CLOSED:
  - closed=1; no grants; requests ignored.
  - ballots_issued is held for Total/Result readout.
- Clear, in any state:
  - Aborts any in-flight ballot: no done, no err, no tally transfer.
  - vote_valid drops the next cycle even without vote_ready.
  - ballots_issued=0, RR pointer=0, close_pend=0, closed=0; state goes to IDLE.
  - Clear and Close in the same cycle: Clear wins; Close is ignored that cycle.
- booth_done and booth_err are never both asserted, and at most one bit of each is set.

Decomposition:
- Shared package vote_pkg holds:
  - state enum: IDLE, WAIT, SEND, CLOSED;
  - NUM_CAND and CNT_W defaults;
  - function onehot_idx returning the valid flag and the index;
  - function popcount_gt1.
- One sub-module: rr_pick, a combinational round-robin picker with inputs req and ptr and output one-hot gnt.

Test Plan:
1. Reset and single vote: Power=0 then 1; booth0 req; booth_in[3:0]=0010 two cycles after grant; vote_ready=1. Expect gnt=0001 one cycle after req, vote_cand=1, booth_done[0] pulse, ballots_issued=1.
2. Round-robin: booths 0 and 2 request continuously, each voting 0001. Expect grant order 0,2,0,2; ballots_issued=4 after 4 handshakes.
3. Spoiled and timeout ballots:
   - booth1 presents 0101: booth_err[1] pulses, no vote_valid, count unchanged.
   - booth1 presents 0000 for 8 cycles: booth_err[1] on the 9th cycle after grant, count unchanged.
4. Backpressure: vote_ready=0 for 5 cycles. vote_valid and vote_cand stay stable; a single increment occurs on the ready cycle.
5. Close mid-ballot: Close pulses during WAIT.
   - The ballot completes (done, count+1), then closed=1.
   - Later requests get no grant; count holds at 12 in a 12-vote session.
6. Clear and power cycle:
   - Clear in SEND with vote_ready=0: valid drops, no done, count=0, closed=0.
   - Power=0 mid-WAIT: all outputs 0 asynchronously; first grant after release goes to booth0.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and helpers for the ballot arbiter.
package vote_pkg;

  localparam int unsigned NUM_CAND_DEF = 4;
  localparam int unsigned CNT_W_DEF    = 12;

  // Helpers operate on a fixed widest ballot; narrower ballots are zero-extended.
  localparam int unsigned CAND_MAX = 32;
  localparam int unsigned CAND_IW  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SEND   = 2'd2,
    CLOSED = 2'd3
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [CAND_IW-1:0] idx;
  } onehot_t;

  // valid is set only when exactly one bit is set; idx is then that bit's position.
  function automatic onehot_t onehot_idx(input logic [CAND_MAX-1:0] v);
    onehot_t r;
    r.valid = (v != '0) && ((v & (v - 1'b1)) == '0);
    r.idx   = '0;
    for (int unsigned i = 0; i < CAND_MAX; i++) begin
      if (v[i]) r.idx = CAND_IW'(i);
    end
    return r;
  endfunction

  function automatic logic popcount_gt1(input logic [CAND_MAX-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          w_found;
  int unsigned   w_sum;
  logic [PW-1:0] w_idx;

  // Scan from ptr upward and grant the first active request.
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_sum   = 0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sum = 32'(ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_idx = w_sum[PW-1:0];
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ballot_arbiter.sv
// Round-robin ballot arbiter sharing one tally among several voting booths.
module ballot_arbiter
  import vote_pkg::*;
#(
  parameter int unsigned NUM_BOOTHS = 4,
  parameter int unsigned NUM_CAND   = NUM_CAND_DEF,
  parameter int unsigned TIMEOUT    = 8,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           Power,
  input  logic                           Clear,
  input  logic                           Close,
  input  logic [NUM_BOOTHS-1:0]          booth_req,
  input  logic [NUM_BOOTHS*NUM_CAND-1:0] booth_in,
  output logic [NUM_BOOTHS-1:0]          booth_gnt,
  output logic [NUM_BOOTHS-1:0]          booth_done,
  output logic [NUM_BOOTHS-1:0]          booth_err,
  output logic                           vote_valid,
  output logic [$clog2(NUM_CAND)-1:0]    vote_cand,
  input  logic                           vote_ready,
  output logic                           closed,
  output logic [CNT_W-1:0]               ballots_issued
);

  localparam int unsigned PW = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;
  localparam int unsigned CW = $clog2(NUM_CAND);

  state_t                r_state, w_state_nxt;
  logic [PW-1:0]         r_ptr, w_ptr_nxt;
  logic [PW-1:0]         r_gidx, w_gidx_nxt;
  logic [7:0]            r_timer, w_timer_nxt;
  logic                  r_close_pend, w_close_pend_nxt;
  logic [NUM_BOOTHS-1:0] r_gnt, w_gnt_nxt;
  logic [NUM_BOOTHS-1:0] r_done, w_done_nxt;
  logic [NUM_BOOTHS-1:0] r_err, w_err_nxt;
  logic                  r_valid, w_valid_nxt;
  logic [CW-1:0]         r_cand, w_cand_nxt;
  logic                  r_closed, w_closed_nxt;
  logic [CNT_W-1:0]      r_count, w_count_nxt;

  logic [NUM_BOOTHS-1:0] w_pick;
  logic [PW-1:0]         w_pick_idx;
  logic [NUM_CAND-1:0]   w_slice;
  logic [CAND_MAX-1:0]   w_slice_ext;
  onehot_t               w_oh;
  logic                  w_spoiled;
  logic                  w_close;
  logic [PW-1:0]         w_ptr_after;
  logic                  w_unused;

  rr_pick #(.N(NUM_BOOTHS), .PW(PW)) u_rr_pick (
    .req (booth_req),
    .ptr (r_ptr),
    .gnt (w_pick)
  );

  // Encode the picker's one-hot grant and select the granted booth's ballot slice.
  always_comb begin
    w_pick_idx = '0;
    w_slice    = '0;
    for (int unsigned b = 0; b < NUM_BOOTHS; b++) begin
      if (w_pick[b]) w_pick_idx = PW'(b);
      if (r_gnt[b])  w_slice    = booth_in[b*NUM_CAND +: NUM_CAND];
    end
  end

  assign w_slice_ext = CAND_MAX'(w_slice);
  assign w_oh        = onehot_idx(w_slice_ext);
  assign w_spoiled   = popcount_gt1(w_slice_ext);
  assign w_close     = Close | r_close_pend;
  assign w_ptr_after = (r_gidx == PW'(NUM_BOOTHS - 1)) ? '0 : r_gidx + 1'b1;
  assign w_unused    = ^w_oh.idx;

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_gidx_nxt       = r_gidx;
    w_timer_nxt      = r_timer;
    w_close_pend_nxt = r_close_pend;
    w_gnt_nxt        = r_gnt;
    w_done_nxt       = '0;
    w_err_nxt        = '0;
    w_valid_nxt      = r_valid;
    w_cand_nxt       = r_cand;
    w_closed_nxt     = r_closed;
    w_count_nxt      = r_count;

    if (Clear) begin
      w_state_nxt      = IDLE;
      w_ptr_nxt        = '0;
      w_timer_nxt      = '0;
      w_close_pend_nxt = 1'b0;
      w_gnt_nxt        = '0;
      w_valid_nxt      = 1'b0;
      w_cand_nxt       = '0;
      w_closed_nxt     = 1'b0;
      w_count_nxt      = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Close) begin
            w_state_nxt  = CLOSED;
            w_closed_nxt = 1'b1;
          end else if (|booth_req) begin
            w_gnt_nxt   = w_pick;
            w_gidx_nxt  = w_pick_idx;
            w_timer_nxt = 8'(TIMEOUT - 1);
            w_state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (Close) w_close_pend_nxt = 1'b1;
          if (w_oh.valid) begin
            w_cand_nxt  = w_oh.idx[CW-1:0];
            w_valid_nxt = 1'b1;
            w_state_nxt = SEND;
          end else if (w_spoiled || (r_timer == '0)) begin
            w_err_nxt        = r_gnt;
            w_gnt_nxt        = '0;
            w_ptr_nxt        = w_ptr_after;
            w_close_pend_nxt = 1'b0;
            w_closed_nxt     = w_close;
            w_state_nxt      = w_close ? CLOSED : IDLE;
          end else begin
            w_timer_nxt = r_timer - 1'b1;
          end
        end
        SEND: begin
          if (Close) w_close_pend_nxt = 1'b1;
          if (r_valid && vote_ready) begin
            w_done_nxt       = r_gnt;
            w_gnt_nxt        = '0;
            w_valid_nxt      = 1'b0;
            w_count_nxt      = (r_count == '1) ? r_count : r_count + 1'b1;
            w_ptr_nxt        = w_ptr_after;
            w_close_pend_nxt = 1'b0;
            w_closed_nxt     = w_close;
            w_state_nxt      = w_close ? CLOSED : IDLE;
          end
        end
        CLOSED: begin
          w_closed_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous power-off reset.
  always_ff @(posedge clk or negedge Power) begin
    if (!Power) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_gidx       <= '0;
      r_timer      <= '0;
      r_close_pend <= 1'b0;
      r_gnt        <= '0;
      r_done       <= '0;
      r_err        <= '0;
      r_valid      <= 1'b0;
      r_cand       <= '0;
      r_closed     <= 1'b0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_gidx       <= w_gidx_nxt;
      r_timer      <= w_timer_nxt;
      r_close_pend <= w_close_pend_nxt;
      r_gnt        <= w_gnt_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_valid      <= w_valid_nxt;
      r_cand       <= w_cand_nxt;
      r_closed     <= w_closed_nxt;
      r_count      <= w_count_nxt;
    end
  end

  assign booth_gnt      = r_gnt;
  assign booth_done     = r_done;
  assign booth_err      = r_err;
  assign vote_valid     = r_valid;
  assign vote_cand      = r_cand;
  assign closed         = r_closed;
  assign ballots_issued = r_count;

endmodule

// File: tb/tb_ballot_arbiter.sv
// Directed self-checking bench for ballot_arbiter.
module tb_ballot_arbiter;

  logic        clk = 1'b0;
  logic        Power = 1'b1;
  logic        Clear = 1'b0;
  logic        Close = 1'b0;
  logic [3:0]  booth_req = '0;
  logic [15:0] booth_in = '0;
  logic [3:0]  booth_gnt, booth_done, booth_err;
  logic        vote_valid;
  logic [1:0]  vote_cand;
  logic        vote_ready = 1'b0;
  logic        closed;
  logic [11:0] ballots_issued;

  int total = 0;
  int bad   = 0;

  ballot_arbiter #(.NUM_BOOTHS(4), .NUM_CAND(4), .TIMEOUT(8), .CNT_W(12)) dut (
    .clk(clk), .Power(Power), .Clear(Clear), .Close(Close),
    .booth_req(booth_req), .booth_in(booth_in),
    .booth_gnt(booth_gnt), .booth_done(booth_done), .booth_err(booth_err),
    .vote_valid(vote_valid), .vote_cand(vote_cand), .vote_ready(vote_ready),
    .closed(closed), .ballots_issued(ballots_issued)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt();
    for (int i = 0; i < 20 && !(|booth_gnt); i++) step();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !(|booth_done); i++) step();
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !vote_valid; i++) step();
  endtask

  task automatic test_reset_single();
    #2 Power = 1'b0;
    #1;
    total++; if (booth_gnt !== 4'b0) begin bad++; $display("FAIL rst_gnt got=%b exp=0000", booth_gnt); end
    total++; if ({booth_done, booth_err} !== 8'b0) begin bad++; $display("FAIL rst_done_err got=%b exp=0", {booth_done, booth_err}); end
    total++; if ({vote_valid, vote_cand, closed} !== 4'b0) begin bad++; $display("FAIL rst_misc got=%b exp=0000", {vote_valid, vote_cand, closed}); end
    total++; if (ballots_issued !== 12'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", ballots_issued); end
    #20 Power = 1'b1;
    step();
    booth_req = 4'b0001;
    step();
    total++; if (booth_gnt !== 4'b0001) begin bad++; $display("FAIL t1_gnt got=%b exp=0001", booth_gnt); end
    step();
    step();
    booth_in = 16'h0002;
    vote_ready = 1'b1;
    step();
    total++; if (vote_valid !== 1'b1) begin bad++; $display("FAIL t1_valid got=%b exp=1", vote_valid); end
    total++; if (vote_cand !== 2'd1) begin bad++; $display("FAIL t1_cand got=%0d exp=1", vote_cand); end
    booth_req = 4'b0000;
    step();
    total++; if (booth_done !== 4'b0001) begin bad++; $display("FAIL t1_done got=%b exp=0001", booth_done); end
    total++; if (ballots_issued !== 12'd1) begin bad++; $display("FAIL t1_count got=%0d exp=1", ballots_issued); end
    total++; if ({booth_gnt, vote_valid} !== 5'b0) begin bad++; $display("FAIL t1_drop got=%b exp=00000", {booth_gnt, vote_valid}); end
    booth_in = '0;
    step();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_order [4];
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0100;
    exp_order[2] = 4'b0001; exp_order[3] = 4'b0100;
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    booth_req = 4'b0101;
    booth_in = 16'h0101;
    vote_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_gnt();
      total++; if (booth_gnt !== exp_order[n]) begin bad++; $display("FAIL rr_gnt%0d got=%b exp=%b", n, booth_gnt, exp_order[n]); end
      wait_done();
      total++; if (booth_done !== exp_order[n]) begin bad++; $display("FAIL rr_done%0d got=%b exp=%b", n, booth_done, exp_order[n]); end
    end
    booth_req = 4'b0000;
    total++; if (ballots_issued !== 12'd4) begin bad++; $display("FAIL rr_count got=%0d exp=4", ballots_issued); end
    booth_in = '0;
    step();
  endtask

  task automatic test_spoil_timeout();
    booth_req = 4'b0010;
    booth_in = 16'h0050;
    wait_gnt();
    total++; if (booth_gnt !== 4'b0010) begin bad++; $display("FAIL sp_gnt got=%b exp=0010", booth_gnt); end
    booth_req = 4'b0000;
    step();
    total++; if (booth_err !== 4'b0010) begin bad++; $display("FAIL sp_err got=%b exp=0010", booth_err); end
    total++; if ({booth_gnt, vote_valid, booth_done} !== 9'b0) begin bad++; $display("FAIL sp_quiet got=%b exp=0", {booth_gnt, vote_valid, booth_done}); end
    total++; if (ballots_issued !== 12'd4) begin bad++; $display("FAIL sp_count got=%0d exp=4", ballots_issued); end
    booth_in = '0;
    step();
    booth_req = 4'b0010;
    wait_gnt();
    total++; if (booth_gnt !== 4'b0010) begin bad++; $display("FAIL to_gnt got=%b exp=0010", booth_gnt); end
    booth_req = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k < 8) begin
        total++; if ({booth_err, booth_gnt} !== 8'b0000_0010) begin bad++; $display("FAIL to_hold%0d got=%b exp=00000010", k, {booth_err, booth_gnt}); end
      end else begin
        total++; if ({booth_err, booth_gnt} !== 8'b0010_0000) begin bad++; $display("FAIL to_err got=%b exp=00100000", {booth_err, booth_gnt}); end
      end
    end
    total++; if (ballots_issued !== 12'd4) begin bad++; $display("FAIL to_count got=%0d exp=4", ballots_issued); end
    step();
  endtask

  task automatic test_backpressure();
    booth_req = 4'b1000;
    booth_in = 16'h8000;
    vote_ready = 1'b0;
    wait_valid();
    booth_req = 4'b0000;
    total++; if ({vote_valid, vote_cand} !== 3'b111) begin bad++; $display("FAIL bp_first got=%b exp=111", {vote_valid, vote_cand}); end
    for (int k = 0; k < 5; k++) begin
      step();
      total++; if ({vote_valid, vote_cand, booth_done} !== 7'b111_0000) begin bad++; $display("FAIL bp_stall%0d got=%b exp=1110000", k, {vote_valid, vote_cand, booth_done}); end
      total++; if (ballots_issued !== 12'd4) begin bad++; $display("FAIL bp_cnt%0d got=%0d exp=4", k, ballots_issued); end
    end
    vote_ready = 1'b1;
    step();
    total++; if (booth_done !== 4'b1000) begin bad++; $display("FAIL bp_done got=%b exp=1000", booth_done); end
    total++; if (ballots_issued !== 12'd5) begin bad++; $display("FAIL bp_count got=%0d exp=5", ballots_issued); end
    total++; if (vote_valid !== 1'b0) begin bad++; $display("FAIL bp_drop got=%b exp=0", vote_valid); end
    booth_in = '0;
    step();
  endtask

  task automatic test_close();
    logic [3:0] exp_g;
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    booth_req = 4'b0011;
    booth_in = 16'h1111;
    vote_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      exp_g = (n % 2 == 0) ? 4'b0001 : 4'b0010;
      wait_gnt();
      total++; if (booth_gnt !== exp_g) begin bad++; $display("FAIL cl_gnt%0d got=%b exp=%b", n, booth_gnt, exp_g); end
      if (n == 11) begin
        booth_in = '0;
        Close = 1'b1;
        step();
        Close = 1'b0;
        booth_in = 16'h1111;
        step();
        total++; if ({vote_valid, closed} !== 2'b10) begin bad++; $display("FAIL cl_inflight got=%b exp=10", {vote_valid, closed}); end
      end
      wait_done();
    end
    total++; if (booth_done !== 4'b0010) begin bad++; $display("FAIL cl_done got=%b exp=0010", booth_done); end
    total++; if (ballots_issued !== 12'd12) begin bad++; $display("FAIL cl_count got=%0d exp=12", ballots_issued); end
    total++; if (closed !== 1'b1) begin bad++; $display("FAIL cl_closed got=%b exp=1", closed); end
    for (int k = 0; k < 6; k++) begin
      step();
      total++; if ({booth_gnt, closed, ballots_issued} !== {4'b0, 1'b1, 12'd12}) begin bad++; $display("FAIL cl_hold%0d gnt=%b closed=%b cnt=%0d exp gnt=0000 closed=1 cnt=12", k, booth_gnt, closed, ballots_issued); end
    end
    booth_req = 4'b0000;
  endtask

  task automatic test_clear_power();
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    total++; if (closed !== 1'b0) begin bad++; $display("FAIL cp_reopen got=%b exp=0", closed); end
    booth_req = 4'b0001;
    booth_in = 16'h1111;
    vote_ready = 1'b1;
    wait_gnt();
    wait_done();
    booth_req = 4'b0000;
    total++; if (ballots_issued !== 12'd1) begin bad++; $display("FAIL cp_count1 got=%0d exp=1", ballots_issued); end
    step();
    booth_req = 4'b0010;
    vote_ready = 1'b0;
    wait_valid();
    total++; if (booth_gnt !== 4'b0010) begin bad++; $display("FAIL cp_gnt got=%b exp=0010", booth_gnt); end
    step();
    step();
    Clear = 1'b1;
    booth_req = 4'b0000;
    step();
    Clear = 1'b0;
    total++; if ({vote_valid, booth_done, booth_gnt, closed} !== 10'b0) begin bad++; $display("FAIL cp_abort got=%b exp=0", {vote_valid, booth_done, booth_gnt, closed}); end
    total++; if (ballots_issued !== 12'd0) begin bad++; $display("FAIL cp_count0 got=%0d exp=0", ballots_issued); end
    booth_in = '0;
    booth_req = 4'b0100;
    wait_gnt();
    total++; if (booth_gnt !== 4'b0100) begin bad++; $display("FAIL pw_gnt got=%b exp=0100", booth_gnt); end
    step();
    step();
    #3 Power = 1'b0;
    #1;
    total++; if ({booth_gnt, booth_done, booth_err, vote_valid, vote_cand, closed} !== 16'b0) begin bad++; $display("FAIL pw_off got=%b exp=0", {booth_gnt, booth_done, booth_err, vote_valid, vote_cand, closed}); end
    #2 Power = 1'b1;
    booth_req = 4'b0101;
    step();
    total++; if (booth_gnt !== 4'b0001) begin bad++; $display("FAIL pw_first got=%b exp=0001", booth_gnt); end
    booth_req = 4'b0000;
    step();
  endtask

  initial begin
    test_reset_single();
    test_round_robin();
    test_spoil_timeout();
    test_backpressure();
    test_close();
    test_clear_power();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
